// File: rtl/riscv_v_hazard_ctrl_if.sv
// Bundle between the vector ID stage / bypass network and the hazard controller.
// The master side drives the ID-stage description and redirect; the slave side returns stall and forwarding qualifiers.
interface riscv_v_hazard_ctrl_if #(
    parameter int RF_ADDR_W  = 5,
    parameter int MC_CNT_W   = 4,
    parameter int PERF_CNT_W = 32
);
    logic                  id_valid;
    logic [RF_ADDR_W-1:0]  id_rs1;
    logic [RF_ADDR_W-1:0]  id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [RF_ADDR_W-1:0]  id_rd;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic [MC_CNT_W-1:0]   id_mc_lat;
    logic                  exe_flush;

    logic                  stall_id;
    logic                  bubble_exe;
    logic                  mc_busy;
    logic                  mem_fwd_vld;
    logic [RF_ADDR_W-1:0]  mem_fwd_rd;
    logic                  wb_fwd_vld;
    logic [RF_ADDR_W-1:0]  wb_fwd_rd;
    logic [PERF_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_mc_lat, exe_flush,
        input  stall_id, bubble_exe, mc_busy, mem_fwd_vld, mem_fwd_rd,
               wb_fwd_vld, wb_fwd_rd, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_mc_lat, exe_flush,
        output stall_id, bubble_exe, mc_busy, mem_fwd_vld, mem_fwd_rd,
               wb_fwd_vld, wb_fwd_rd, stall_cnt
    );
endinterface

// File: rtl/riscv_v_hazard_ctrl.sv
// Vector pipeline hazard controller: shadow EXE/MEM/WB destination tags, load-use stall,
// multi-cycle EXE occupancy freeze and a saturating stall-cycle counter.
module riscv_v_hazard_ctrl #(
    parameter int RF_ADDR_W  = 5,
    parameter int MC_CNT_W   = 4,
    parameter int PERF_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_v_hazard_ctrl_if.slave   hz
);

    // The load flag only matters while the producer sits in EXE, so MEM/WB drop it.
    typedef struct packed {
        logic                 vld;
        logic [RF_ADDR_W-1:0] rd;
        logic                 we;
        logic                 ld;
    } exe_entry_t;

    typedef struct packed {
        logic                 vld;
        logic [RF_ADDR_W-1:0] rd;
        logic                 we;
    } fwd_entry_t;

    typedef enum logic {
        IDLE,
        MC_BUSY
    } state_t;

    state_t                state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
    exe_entry_t            exe_q, exe_d;
    fwd_entry_t            mem_q, mem_d;
    fwd_entry_t            wb_q, wb_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    exe_entry_t id_entry;
    fwd_entry_t exe_to_mem;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       mc_issue;
    logic       stall_c;
    logic       bubble_c;

    always_comb begin
        id_entry.vld = hz.id_valid;
        id_entry.rd  = hz.id_rd;
        id_entry.we  = hz.id_rd_we;
        id_entry.ld  = hz.id_is_load;

        exe_to_mem.vld = exe_q.vld;
        exe_to_mem.rd  = exe_q.rd;
        exe_to_mem.we  = exe_q.we;

        rs1_hit  = hz.id_rs1_used && (hz.id_rs1 == exe_q.rd);
        rs2_hit  = hz.id_rs2_used && (hz.id_rs2 == exe_q.rd);
        load_use = hz.id_valid && exe_q.vld && exe_q.we && exe_q.ld && (rs1_hit || rs2_hit);
        mc_issue = hz.id_valid && (hz.id_mc_lat > MC_CNT_W'(1));
    end

    // Hazard priority: redirect, then multi-cycle freeze, then load-use, else normal advance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exe_d    = exe_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;

        if (hz.exe_flush) begin
            exe_d    = '0;
            mem_d    = '0;
            wb_d     = mem_q;
            state_d  = IDLE;
            cnt_d    = '0;
            bubble_c = 1'b1;
        end else if (state_q == MC_BUSY) begin
            stall_c = 1'b1;
            mem_d   = '0;
            wb_d    = mem_q;
            cnt_d   = cnt_q - MC_CNT_W'(1);
            if (cnt_q == MC_CNT_W'(1)) begin
                state_d = IDLE;
            end
        end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            exe_d    = '0;
            mem_d    = exe_to_mem;
            wb_d     = mem_q;
        end else begin
            exe_d = id_entry;
            mem_d = exe_to_mem;
            wb_d  = mem_q;
            if (mc_issue) begin
                state_d = MC_BUSY;
                cnt_d   = hz.id_mc_lat - MC_CNT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {PERF_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset is also folded into the combinational outputs so they read 0 while it is held.
    assign hz.stall_id    = stall_c && !rst;
    assign hz.bubble_exe  = bubble_c && !rst;
    assign hz.mc_busy     = (state_q == MC_BUSY);
    assign hz.mem_fwd_vld = mem_q.vld && mem_q.we;
    assign hz.mem_fwd_rd  = mem_q.rd;
    assign hz.wb_fwd_vld  = wb_q.vld && wb_q.we;
    assign hz.wb_fwd_rd   = wb_q.rd;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_riscv_v_hazard_ctrl.sv
// Directed bench for riscv_v_hazard_ctrl; a 4-bit stall counter makes saturation reachable.
module tb_riscv_v_hazard_ctrl;

    localparam int RF_ADDR_W  = 5;
    localparam int MC_CNT_W   = 4;
    localparam int PERF_CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   failed   = 0;

    riscv_v_hazard_ctrl_if #(.RF_ADDR_W(RF_ADDR_W), .MC_CNT_W(MC_CNT_W), .PERF_CNT_W(PERF_CNT_W)) hz ();

    riscv_v_hazard_ctrl #(.RF_ADDR_W(RF_ADDR_W), .MC_CNT_W(MC_CNT_W), .PERF_CNT_W(PERF_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                            input logic we, input logic ld, input logic [3:0] lat);
        hz.id_valid    = v;
        hz.id_rs1      = rs1;
        hz.id_rs1_used = u1;
        hz.id_rs2      = rs2;
        hz.id_rs2_used = u2;
        hz.id_rd       = rd;
        hz.id_rd_we    = we;
        hz.id_is_load  = ld;
        hz.id_mc_lat   = lat;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hz.exe_flush = 1'b0;
        idle_id();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        compared++; if (hz.stall_id !== 1'b0)    begin failed++; $display("[TB] FAIL rst_stall_id: got %0b want 0", hz.stall_id); end
        compared++; if (hz.bubble_exe !== 1'b0)  begin failed++; $display("[TB] FAIL rst_bubble: got %0b want 0", hz.bubble_exe); end
        compared++; if (hz.mc_busy !== 1'b0)     begin failed++; $display("[TB] FAIL rst_mc_busy: got %0b want 0", hz.mc_busy); end
        compared++; if (hz.mem_fwd_vld !== 1'b0) begin failed++; $display("[TB] FAIL rst_mem_vld: got %0b want 0", hz.mem_fwd_vld); end
        compared++; if (hz.wb_fwd_vld !== 1'b0)  begin failed++; $display("[TB] FAIL rst_wb_vld: got %0b want 0", hz.wb_fwd_vld); end
        compared++; if (hz.stall_cnt !== 4'd0)   begin failed++; $display("[TB] FAIL rst_stall_cnt: got %0d want 0", hz.stall_cnt); end
        rst = 1'b0;
        tick();
        compared++; if (hz.bubble_exe !== 1'b0)  begin failed++; $display("[TB] FAIL idle_no_bubble: got %0b want 0", hz.bubble_exe); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 4'd0);
        #1;
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL lu_load_accept: got %0b want 0", hz.stall_id); end
        tick();
        drive_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 4'd0);
        #1;
        compared++; if (hz.stall_id !== 1'b1)   begin failed++; $display("[TB] FAIL lu_stall: got %0b want 1", hz.stall_id); end
        compared++; if (hz.bubble_exe !== 1'b1) begin failed++; $display("[TB] FAIL lu_bubble: got %0b want 1", hz.bubble_exe); end
        tick();
        compared++; if (hz.stall_id !== 1'b0)   begin failed++; $display("[TB] FAIL lu_one_cycle: got %0b want 0", hz.stall_id); end
        compared++; if (hz.mem_fwd_rd !== 5'd3) begin failed++; $display("[TB] FAIL lu_mem_rd: got %0d want 3", hz.mem_fwd_rd); end
        tick();
        idle_id();
        #1;
        compared++; if (hz.wb_fwd_vld !== 1'b1)  begin failed++; $display("[TB] FAIL lu_wb_vld: got %0b want 1", hz.wb_fwd_vld); end
        compared++; if (hz.wb_fwd_rd !== 5'd3)   begin failed++; $display("[TB] FAIL lu_wb_rd: got %0d want 3", hz.wb_fwd_rd); end
        compared++; if (hz.mem_fwd_vld !== 1'b0) begin failed++; $display("[TB] FAIL lu_mem_bubble: got %0b want 0", hz.mem_fwd_vld); end
        compared++; if (hz.stall_cnt !== 4'd1)   begin failed++; $display("[TB] FAIL lu_stall_cnt: got %0d want 1", hz.stall_cnt); end
    endtask

    task automatic test_scalar_src();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 4'd0);
        tick();
        drive_id(1'b1, 5'd3, 1'b0, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 4'd0);
        #1;
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL scalar_no_stall: got %0b want 0", hz.stall_id); end
        tick();
        idle_id();
        #1;
        compared++; if (hz.stall_cnt !== 4'd0)   begin failed++; $display("[TB] FAIL scalar_cnt: got %0d want 0", hz.stall_cnt); end
        compared++; if (hz.mem_fwd_vld !== 1'b1) begin failed++; $display("[TB] FAIL scalar_mem_vld: got %0b want 1", hz.mem_fwd_vld); end
        compared++; if (hz.mem_fwd_rd !== 5'd3)  begin failed++; $display("[TB] FAIL scalar_mem_rd: got %0d want 3", hz.mem_fwd_rd); end
    endtask

    task automatic test_load_gap();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 4'd0);
        tick();
        drive_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 1'b0, 4'd0);
        tick();
        drive_id(1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 4'd0);
        #1;
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL gap_no_stall: got %0b want 0", hz.stall_id); end
        tick();
        idle_id();
        #1;
        compared++; if (hz.wb_fwd_vld !== 1'b1) begin failed++; $display("[TB] FAIL gap_wb_vld: got %0b want 1", hz.wb_fwd_vld); end
        compared++; if (hz.wb_fwd_rd !== 5'd3)  begin failed++; $display("[TB] FAIL gap_wb_rd: got %0d want 3", hz.wb_fwd_rd); end
        compared++; if (hz.mem_fwd_rd !== 5'd6) begin failed++; $display("[TB] FAIL gap_mem_rd: got %0d want 6", hz.mem_fwd_rd); end
        compared++; if (hz.stall_cnt !== 4'd0)  begin failed++; $display("[TB] FAIL gap_cnt: got %0d want 0", hz.stall_cnt); end
    endtask

    task automatic test_mc_op();
        int busy_cycles;
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 4'd0);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 4'd4);
        #1;
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL mc_issue_accept: got %0b want 0", hz.stall_id); end
        tick();
        compared++; if (hz.mem_fwd_rd !== 5'd9) begin failed++; $display("[TB] FAIL mc_prev_mem_rd: got %0d want 9", hz.mem_fwd_rd); end
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 4'd0);
        #1;
        busy_cycles = 0;
        for (int i = 0; i < 20 && hz.mc_busy === 1'b1; i++) begin
            compared++; if (hz.stall_id !== 1'b1) begin failed++; $display("[TB] FAIL mc_stall[%0d]: got %0b want 1", i, hz.stall_id); end
            busy_cycles++;
            tick();
            compared++; if (hz.mem_fwd_vld !== 1'b0) begin failed++; $display("[TB] FAIL mc_mem_bubble[%0d]: got %0b want 0", i, hz.mem_fwd_vld); end
        end
        compared++; if (busy_cycles != 3)     begin failed++; $display("[TB] FAIL mc_busy_cycles: got %0d want 3", busy_cycles); end
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL mc_release: got %0b want 0", hz.stall_id); end
        tick();
        compared++; if (hz.mem_fwd_vld !== 1'b1) begin failed++; $display("[TB] FAIL mc_exit_mem_vld: got %0b want 1", hz.mem_fwd_vld); end
        compared++; if (hz.mem_fwd_rd !== 5'd10) begin failed++; $display("[TB] FAIL mc_exit_mem_rd: got %0d want 10", hz.mem_fwd_rd); end
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 4'd0);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 4'd0);
        tick();
        idle_id();
        #1;
        compared++; if (hz.mem_fwd_rd !== 5'd12) begin failed++; $display("[TB] FAIL mc_alu_flow: got %0d want 12", hz.mem_fwd_rd); end
        compared++; if (hz.stall_cnt !== 4'd3)   begin failed++; $display("[TB] FAIL mc_stall_cnt: got %0d want 3", hz.stall_cnt); end
    endtask

    task automatic test_mc_flush();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 4'd5);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 4'd0);
        #1;
        compared++; if (hz.mc_busy !== 1'b1) begin failed++; $display("[TB] FAIL mcf_busy: got %0b want 1", hz.mc_busy); end
        tick();
        hz.exe_flush = 1'b1;
        #1;
        compared++; if (hz.stall_id !== 1'b0)   begin failed++; $display("[TB] FAIL mcf_flush_stall: got %0b want 0", hz.stall_id); end
        compared++; if (hz.bubble_exe !== 1'b1) begin failed++; $display("[TB] FAIL mcf_flush_bubble: got %0b want 1", hz.bubble_exe); end
        tick();
        hz.exe_flush = 1'b0;
        #1;
        compared++; if (hz.mc_busy !== 1'b0)  begin failed++; $display("[TB] FAIL mcf_idle: got %0b want 0", hz.mc_busy); end
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL mcf_accept: got %0b want 0", hz.stall_id); end
        tick();
        idle_id();
        #1;
        compared++; if (hz.mem_fwd_vld !== 1'b0) begin failed++; $display("[TB] FAIL mcf_exe_killed: got %0b want 0", hz.mem_fwd_vld); end
        tick();
        compared++; if (hz.mem_fwd_vld !== 1'b1) begin failed++; $display("[TB] FAIL mcf_next_vld: got %0b want 1", hz.mem_fwd_vld); end
        compared++; if (hz.mem_fwd_rd !== 5'd13) begin failed++; $display("[TB] FAIL mcf_next_rd: got %0d want 13", hz.mem_fwd_rd); end
        compared++; if (hz.stall_cnt !== 4'd1)   begin failed++; $display("[TB] FAIL mcf_cnt: got %0d want 1", hz.stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 4'd0);
        tick();
        drive_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b1, 4'd0);
        #1;
        compared++; if (hz.stall_id !== 1'b1) begin failed++; $display("[TB] FAIL b2b_rs2_stall: got %0b want 1", hz.stall_id); end
        hz.exe_flush = 1'b1;
        #1;
        compared++; if (hz.stall_id !== 1'b0)   begin failed++; $display("[TB] FAIL b2b_flush_prio: got %0b want 0", hz.stall_id); end
        compared++; if (hz.bubble_exe !== 1'b1) begin failed++; $display("[TB] FAIL b2b_flush_bubble: got %0b want 1", hz.bubble_exe); end
        tick();
        hz.exe_flush = 1'b0;
        #1;
        compared++; if (hz.stall_id !== 1'b0) begin failed++; $display("[TB] FAIL b2b_after_flush: got %0b want 0", hz.stall_id); end
        tick();
        idle_id();
        tick();
        compared++; if (hz.mem_fwd_rd !== 5'd8) begin failed++; $display("[TB] FAIL b2b_mem_rd: got %0d want 8", hz.mem_fwd_rd); end
    endtask

    task automatic test_reset_mid_mc();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 4'd0);
        tick();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 4'd9);
        tick();
        drive_id(1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0, 4'd0);
        tick();
        compared++; if (hz.mc_busy !== 1'b1)    begin failed++; $display("[TB] FAIL rmc_busy: got %0b want 1", hz.mc_busy); end
        compared++; if (hz.stall_cnt !== 4'd1)  begin failed++; $display("[TB] FAIL rmc_cnt: got %0d want 1", hz.stall_cnt); end
        compared++; if (hz.wb_fwd_rd !== 5'd20) begin failed++; $display("[TB] FAIL rmc_wb_rd: got %0d want 20", hz.wb_fwd_rd); end
        rst = 1'b1;
        #1;
        compared++; if (hz.stall_id !== 1'b0)   begin failed++; $display("[TB] FAIL rmc_stall: got %0b want 0", hz.stall_id); end
        compared++; if (hz.mc_busy !== 1'b0)    begin failed++; $display("[TB] FAIL rmc_idle: got %0b want 0", hz.mc_busy); end
        compared++; if (hz.stall_cnt !== 4'd0)  begin failed++; $display("[TB] FAIL rmc_cnt_clr: got %0d want 0", hz.stall_cnt); end
        compared++; if (hz.wb_fwd_vld !== 1'b0) begin failed++; $display("[TB] FAIL rmc_wb_vld: got %0b want 0", hz.wb_fwd_vld); end
        compared++; if (hz.wb_fwd_rd !== 5'd0)  begin failed++; $display("[TB] FAIL rmc_wb_rd_clr: got %0d want 0", hz.wb_fwd_rd); end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 4'd15);
        tick();
        idle_id();
        repeat (14) tick();
        compared++; if (hz.mc_busy !== 1'b0)   begin failed++; $display("[TB] FAIL sat_idle: got %0b want 0", hz.mc_busy); end
        compared++; if (hz.stall_cnt !== 4'd14) begin failed++; $display("[TB] FAIL sat_cnt14: got %0d want 14", hz.stall_cnt); end
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 4'd15);
        tick();
        idle_id();
        tick();
        compared++; if (hz.stall_cnt !== 4'd15) begin failed++; $display("[TB] FAIL sat_cnt15: got %0d want 15", hz.stall_cnt); end
        tick();
        compared++; if (hz.stall_cnt !== 4'd15) begin failed++; $display("[TB] FAIL sat_hold: got %0d want 15", hz.stall_cnt); end
        repeat (12) tick();
        compared++; if (hz.stall_cnt !== 4'd15) begin failed++; $display("[TB] FAIL sat_end: got %0d want 15", hz.stall_cnt); end
    endtask

    initial begin
        $display("[TB] starting riscv_v_hazard_ctrl bench");
        test_reset();
        test_load_use();
        test_scalar_src();
        test_load_gap();
        test_mc_op();
        test_mc_flush();
        test_back_to_back();
        test_reset_mid_mc();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
